// File: rtl/pe_array_ctrl.sv
// Sequencer for a column of ROWS chained PE multiply-accumulate cells.
// It drives the operand-buffer reads and the skewed per-row PE enables, and
// emits one result-capture strobe per row at the end of each tile.
// Optional build macro PE_CTRL_PERF_EN enables the stall-cycle counter;
// without it perf_stall_cycles is tied to zero.
module pe_array_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DIMENSION = 16,
    parameter int ROWS      = 4,
    parameter int ADDR_W    = 4,
    parameter int TILE_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TILE_W-1:0] n_tiles,
    input  logic              op_ready,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] k_addr,
    output logic [TILE_W-1:0] tile_idx,
    output logic [ROWS-1:0]   pe_en,
    output logic [ROWS-1:0]   res_valid,
    output logic [TILE_W-1:0] res_tile,
    output logic [15:0]       perf_stall_cycles
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int                DRN_W    = $clog2(ROWS + 2);
    localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(DIMENSION - 1);
    localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'(ROWS);

    // WIDTH only documents the PE operand width; reject nonsensical setups.
    if (WIDTH < 1 || (2 ** ADDR_W) < DIMENSION) begin : g_param_check
        $error("pe_array_ctrl: bad WIDTH or ADDR_W too small for DIMENSION");
    end

    state_t            state_q;
    logic [TILE_W-1:0] ntiles_q;
    logic [TILE_W-1:0] tile_q;
    logic [ADDR_W-1:0] k_q;
    logic [DRN_W-1:0]  drn_q;
    logic              busy_q;
    logic              done_q;
    logic              rd_en_q;

    logic [ROWS-1:0]   pe_q;
    logic [ROWS-1:0]   lb_q;
    logic [ROWS-1:0]   rv_q;
    logic [TILE_W-1:0] tag_q;
    logic [TILE_W-1:0] res_tile_q;

    logic [TILE_W-1:0] tile_nxt;
    logic              tile_end;
    logic              more_tiles;
    logic              start_acc;

    assign tile_nxt   = tile_q + TILE_W'(1);
    assign tile_end   = (state_q == S_RUN) && (k_q == K_LAST);
    assign more_tiles = (tile_nxt != ntiles_q);
    assign start_acc  = (state_q == S_IDLE) && start && (n_tiles != '0);

    // Job sequencer: start/busy/done handshake, tile and beat counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            ntiles_q <= '0;
            tile_q   <= '0;
            k_q      <= '0;
            drn_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_acc) begin
                        ntiles_q <= n_tiles;
                        tile_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (op_ready) begin
                        rd_en_q <= 1'b1;
                        k_q     <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    // op_ready is only looked at here, on the last beat, so a
                    // mid-tile drop never breaks the PE accumulation.
                    if (tile_end) begin
                        tile_q <= tile_nxt;
                        k_q    <= '0;
                        if (!more_tiles) begin
                            rd_en_q <= 1'b0;
                            drn_q   <= '0;
                            state_q <= S_DRAIN;
                        end else if (!op_ready) begin
                            rd_en_q <= 1'b0;
                            state_q <= S_WAIT;
                        end
                    end else begin
                        k_q <= k_q + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (drn_q == DRN_LAST) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        drn_q <= drn_q + DRN_W'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Enable skew and last-beat marker; keeps shifting in WAIT so strobes drain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pe_q       <= '0;
            lb_q       <= '0;
            rv_q       <= '0;
            tag_q      <= '0;
            res_tile_q <= '0;
        end else begin
            pe_q  <= ROWS'({pe_q, rd_en_q});
            lb_q  <= ROWS'({lb_q, rd_en_q && (k_q == K_LAST)});
            rv_q  <= lb_q;
            tag_q <= tile_q;
            if (lb_q[0]) begin
                res_tile_q <= tag_q;
            end
        end
    end

`ifdef PE_CTRL_PERF_EN
    logic [15:0] perf_q;
    logic        stall_d;

    // A stall is a WAIT cycle caused by op_ready being low; the single
    // mandatory WAIT cycle right after start is not counted.
    assign stall_d = (op_ready == 1'b0) &&
                     ((state_q == S_WAIT) || (tile_end && more_tiles));

    // Saturating stall counter, cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_q <= '0;
        end else if (start_acc) begin
            perf_q <= '0;
        end else if (stall_d && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_stall_cycles = perf_q;
`else
    assign perf_stall_cycles = 16'h0000;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign k_addr    = k_q;
    assign tile_idx  = tile_q;
    assign pe_en     = pe_q;
    assign res_valid = rv_q;
    assign res_tile  = res_tile_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Randomized bench for pe_array_ctrl with a timeline reference model.
module tb_pe_array_ctrl;

    localparam int D    = 16;
    localparam int R    = 4;
    localparam int AW   = 4;
    localparam int TW   = 8;
    localparam int MAXC = 400;

    logic          clk;
    logic          rst;
    logic          start;
    logic [TW-1:0] n_tiles;
    logic          op_ready;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] k_addr;
    logic [TW-1:0] tile_idx;
    logic [R-1:0]  pe_en;
    logic [R-1:0]  res_valid;
    logic [TW-1:0] res_tile;
    logic [15:0]   perf_stall_cycles;

    pe_array_ctrl #(.WIDTH(8), .DIMENSION(D), .ROWS(R), .ADDR_W(AW), .TILE_W(TW)) dut (
        .clk(clk), .rst(rst), .start(start), .n_tiles(n_tiles), .op_ready(op_ready),
        .busy(busy), .done(done), .rd_en(rd_en), .k_addr(k_addr), .tile_idx(tile_idx),
        .pe_en(pe_en), .res_valid(res_valid), .res_tile(res_tile),
        .perf_stall_cycles(perf_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference timeline, indexed by cycle within a job (cycle 1 = first busy cycle).
    bit         rdy   [MAXC];
    bit         e_rd  [MAXC];
    int         e_k   [MAXC];
    int         e_tile[MAXC];
    bit [R-1:0] e_pe  [MAXC];
    bit [R-1:0] e_rv  [MAXC];
    int         e_rt  [MAXC];
    int         rt_at [MAXC];
    bit         e_busy[MAXC];
    bit         e_done[MAXC];
    int         done_cyc;
    int         stall_exp;
    int         prev_rt = 0;

    task automatic gen_rdy(input int pct);
        for (int c = 0; c < MAXC; c++)
            rdy[c] = ($urandom_range(99) < pct) || (c % 5 == 0);
    endtask

    // Tiles start one cycle after op_ready is seen at the first boundary or
    // WAIT cycle; every row strobes two cycles after its last beat plus skew.
    task automatic build_model(input int n);
        int t_edge, e, s, L;
        int lasts[$];
        int cur;
        for (int c = 0; c < MAXC; c++) begin
            e_rd[c] = 0; e_k[c] = 0; e_tile[c] = 0; e_pe[c] = '0; e_rv[c] = '0;
            rt_at[c] = -1; e_busy[c] = 0; e_done[c] = 0;
        end
        stall_exp = 0;
        t_edge = 1;
        L = 0;
        for (int t = 0; t < n; t++) begin
            e = t_edge;
            while (!rdy[e]) e++;
            stall_exp += e - t_edge;
            s = e + 1;
            L = s + D - 1;
            for (int c = s; c <= L; c++) begin
                e_rd[c] = 1;
                e_k[c] = c - s;
                for (int r = 0; r < R; r++) e_pe[c + 1 + r][r] = 1'b1;
            end
            for (int r = 0; r < R; r++) e_rv[L + 2 + r][r] = 1'b1;
            rt_at[L + 2] = t;
            lasts.push_back(L);
            t_edge = L;
        end
        done_cyc = L + R + 2;
        for (int c = 1; c <= done_cyc; c++) e_busy[c] = 1;
        e_done[done_cyc] = 1;
        for (int c = 1; c <= done_cyc + 1; c++) begin
            e_tile[c] = 0;
            foreach (lasts[i]) if (lasts[i] < c) e_tile[c]++;
        end
        cur = prev_rt;
        for (int c = 0; c <= done_cyc + 1; c++) begin
            if (rt_at[c] >= 0) cur = rt_at[c];
            e_rt[c] = cur;
        end
    endtask

    function automatic int perf_exp(input int stalls);
`ifdef PE_CTRL_PERF_EN
        return stalls;
`else
        return 0;
`endif
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_k_addr"}, k_addr, 0);
        chk({tag, "_tile_idx"}, tile_idx, 0);
        chk({tag, "_pe_en"}, pe_en, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_tile"}, res_tile, 0);
        chk({tag, "_perf"}, perf_stall_cycles, 0);
    endtask

    // Runs one job; abort_at>0 pulls reset during that cycle, spur adds
    // ignored start pulses while busy.
    task automatic run_job(input string name, input int n, input int abort_at, input bit spur);
        build_model(n);
        @(negedge clk);
        start = 1'b1; n_tiles = TW'(n); op_ready = rdy[0];
        for (int c = 1; c < MAXC - 1; c++) begin
            @(negedge clk);
            if (abort_at != 0 && c == abort_at + 1) begin
                chk_zero({name, "_abort"});
                rst = 1'b1;
                prev_rt = 0;
                break;
            end
            chk({name, "_busy"}, busy, e_busy[c]);
            chk({name, "_done"}, done, e_done[c]);
            chk({name, "_rd_en"}, rd_en, e_rd[c]);
            chk({name, "_k_addr"}, k_addr, e_k[c]);
            chk({name, "_tile_idx"}, tile_idx, e_tile[c]);
            chk({name, "_pe_en"}, pe_en, e_pe[c]);
            chk({name, "_res_valid"}, res_valid, e_rv[c]);
            chk({name, "_res_tile"}, res_tile, e_rt[c]);
            if (c == done_cyc) chk({name, "_perf"}, perf_stall_cycles, perf_exp(stall_exp));
            if (c == done_cyc + 1) begin
                prev_rt = e_rt[c];
                break;
            end
            start    = spur && ($urandom_range(3) == 0);
            n_tiles  = TW'($urandom);
            op_ready = rdy[c];
            rst      = (c == abort_at) ? 1'b0 : 1'b1;
        end
        start = 1'b0; op_ready = 1'b0; rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; n_tiles = '0; op_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        gen_rdy(100);
        run_job("single", 1, 0, 1'b0);

        gen_rdy(100);
        run_job("three", 3, 0, 1'b0);

        gen_rdy(100);
        for (int c = 17; c <= 21; c++) rdy[c] = 1'b0;
        run_job("gap", 2, 0, 1'b0);
        chk("gap_perf_after_done", perf_stall_cycles, perf_exp(5));

        gen_rdy(100);
        for (int c = 6; c <= 12; c++) rdy[c] = 1'b0;
        run_job("midtile", 1, 0, 1'b0);

        start = 1'b1; n_tiles = '0; op_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("zero_start_busy", busy, 0);
            chk("zero_start_rd_en", rd_en, 0);
        end

        gen_rdy(100);
        run_job("spurious", 2, 0, 1'b1);

        gen_rdy(100);
        run_job("abort", 2, 10, 1'b0);
        repeat (30) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        gen_rdy(100);
        run_job("after_abort", 1, 0, 1'b0);

        for (int j = 0; j < 8; j++) begin
            gen_rdy($urandom_range(30, 90));
            if (j == 5) run_job("rand_abort", $urandom_range(1, 4), $urandom_range(2, 15), 1'b1);
            else        run_job("rand", $urandom_range(1, 4), 0, $urandom_range(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
